// File: rtl/adder_share_pkg.sv
// Shared types, constants and helpers for the shared-adder controller.
package adder_share_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  localparam logic [WIDTH_DEF-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [WIDTH_DEF-1:0] SAT_NEG = 32'h8000_0000;

  // Two's-complement add overflows when like-signed operands give an unlike-signed sum.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the favoured port flips only when both request.
module rr_arb2 (
  input  logic       gclk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic ptr_q;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge gclk) begin
    if (rst)                   ptr_q <= 1'b0;
    else if (enable && &req)   ptr_q <= ~ptr_q;
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Two-port shared signed adder gated on PLL lock, one result register deep.
// Define ADDER_SAT_EN to clamp overflowed sums instead of wrapping.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int LOCK_STABLE = 8,
  parameter int CNT_W       = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_of,
  output logic             run,
  output logic [CNT_W-1:0] of_count
);

  localparam int LW = $clog2(LOCK_STABLE + 1);

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] sum;
    logic             of;
  } resp_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    stab_q, stab_d;
  resp_t            resp_q, resp_d;
  logic             vld_q;
  logic [CNT_W-1:0] ofc_q;

  logic             slot_free, arb_en, accept;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] op_a, op_b, raw_sum, sum_sel;
  logic             ovf;

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    case (state_q)
      WAIT_LOCK: begin
        if (!locked) begin
          stab_d = '0;
        end else if (stab_q == LW'(LOCK_STABLE - 1)) begin
          state_d = RUN;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked) begin
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // A held result blocks new grants unless it leaves this same cycle.
  assign slot_free = !vld_q || resp_ready;
  assign arb_en    = (state_q == RUN) && locked && slot_free;

  rr_arb2 u_arb (
    .gclk   (refclk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .enable (arb_en),
    .gnt    (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accept     = |gnt;

  assign op_a    = gnt[1] ? req1_a : req0_a;
  assign op_b    = gnt[1] ? req1_b : req0_b;
  assign raw_sum = op_a + op_b;
  assign ovf     = add_ovf(op_a[WIDTH-1], op_b[WIDTH-1], raw_sum[WIDTH-1]);

`ifdef ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_P = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_N = {1'b1, {(WIDTH-1){1'b0}}};
  assign sum_sel = ovf ? (op_a[WIDTH-1] ? SAT_N : SAT_P) : raw_sum;
`else
  assign sum_sel = raw_sum;
`endif

  assign resp_d = '{id: gnt[1], sum: sum_sel, of: ovf};

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      stab_q  <= '0;
      vld_q   <= 1'b0;
      resp_q  <= '0;
      ofc_q   <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      if (vld_q && resp_ready && resp_q.of && (ofc_q != '1))
        ofc_q <= ofc_q + 1'b1;
      // Losing lock drops an undelivered result rather than presenting it later.
      if ((state_q == RUN) && !locked) begin
        vld_q <= 1'b0;
      end else if (accept) begin
        vld_q  <= 1'b1;
        resp_q <= resp_d;
      end else if (resp_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign resp_valid = vld_q;
  assign resp_id    = resp_q.id;
  assign resp_sum   = resp_q.sum;
  assign resp_of    = resp_q.of;
  assign run        = (state_q == RUN);
  assign of_count   = ofc_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl: scoreboard on responses plus directed corner sequences.
module tb_adder_share_ctrl;

  logic        refclk = 1'b0;
  logic        rst = 1'b1, locked = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready, resp_valid, resp_id, resp_of, run;
  logic [31:0] resp_sum;
  logic [15:0] of_count;

  adder_share_ctrl dut (
    .refclk(refclk), .rst(rst), .locked(locked),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_of(resp_of), .run(run), .of_count(of_count)
  );

  always #5 refclk = ~refclk;

`ifdef ADDER_SAT_EN
  localparam logic [31:0] OVP_SUM = 32'h7FFF_FFFF;
  localparam logic [31:0] OVN_SUM = 32'h8000_0000;
`else
  localparam logic [31:0] OVP_SUM = 32'h8000_0000;
  localparam logic [31:0] OVN_SUM = 32'h7FFF_FFFF;
`endif

  typedef struct packed { logic id; logic [31:0] sum; logic of; } exp_t;
  typedef struct { int port; logic [31:0] a; logic [31:0] b; logic [31:0] sum; logic of; } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] pend_sum [2];
  logic        pend_of  [2];
  int          checks = 0, failures = 0, exp_ofc = 0;
  vec_t        tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: push on request handshake, pop on response handshake.
  always @(negedge refclk) begin
    chk("of_count", 64'(of_count), 64'(exp_ofc));
    if (rst) begin
      sb.delete();
      exp_ofc = 0;
    end else begin
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 64'(1), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("resp_id", 64'(resp_id), 64'(mon_e.id));
          chk("resp_sum", 64'(resp_sum), 64'(mon_e.sum));
          chk("resp_of", 64'(resp_of), 64'(mon_e.of));
          if (mon_e.of) exp_ofc++;
        end
      end else if (resp_valid && !locked) begin
        if (sb.size() != 0) void'(sb.pop_front());
      end
      if (req0_valid && req0_ready) sb.push_back({1'b0, pend_sum[0], pend_of[0]});
      if (req1_valid && req1_ready) sb.push_back({1'b1, pend_sum[1], pend_of[1]});
    end
  end

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] es, input logic eo);
    pend_sum[p] = es;
    pend_of[p]  = eo;
    if (p == 0) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else        begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
  endtask

  task automatic send(input vec_t v);
    int n = 0;
    logic rdy = 1'b0;
    set_req(v.port, v.a, v.b, v.sum, v.of);
    while (!rdy && n < 20) begin
      @(negedge refclk);
      n++;
      rdy = (v.port == 0) ? req0_ready : req1_ready;
    end
    if (!rdy) chk("send_timeout", 64'(0), 64'(1));
    step();
    if (v.port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_run(input int exp_n);
    int n = 0;
    logic up = 1'b0;
    while (!up && n < 40) begin
      @(posedge refclk);
      @(negedge refclk);
      n++;
      if (run) up = 1'b1;
      else begin
        chk("gate_ready0", 64'(req0_ready), 64'(0));
        chk("gate_ready1", 64'(req1_ready), 64'(0));
      end
    end
    chk("lock_cycles", 64'(n), 64'(exp_n));
  endtask

  initial begin
    int c0, c1;
    vec_t v;
    tbl[0] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, OVP_SUM,      1'b1};
    tbl[1] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, OVN_SUM,      1'b1};
    tbl[2] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,        1'b0};
    tbl[3] = '{1, 32'hFFFF_FFFB, 32'h0000_0003, 32'hFFFF_FFFE, 1'b0};
    tbl[4] = '{0, 32'h4000_0000, 32'h4000_0000, OVP_SUM,      1'b1};
    tbl[5] = '{0, 32'hC000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0};

    // Reset state
    repeat (5) step();
    @(negedge refclk);
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_sum",   64'(resp_sum),   64'(0));
    chk("rst_resp_id",    64'(resp_id),    64'(0));
    chk("rst_resp_of",    64'(resp_of),    64'(0));
    chk("rst_run",        64'(run),        64'(0));
    chk("rst_ready",      64'({req0_ready, req1_ready}), 64'(0));
    step();
    rst = 1'b0;

    // Lock gating with a glitch; requester already waiting
    resp_ready = 1'b1;
    set_req(0, 32'd1, 32'd1, 32'd2, 1'b0);
    locked = 1'b1;
    repeat (3) step();
    locked = 1'b0;
    step();
    locked = 1'b1;
    wait_run(8);
    step();
    req0_valid = 1'b0;

    // Back-to-back on port 0, one-cycle latency
    set_req(0, 32'd10, 32'd20, 32'd30, 1'b0);
    @(negedge refclk);
    chk("b2b_ready_a", 64'(req0_ready), 64'(1));
    step();
    set_req(0, 32'd100, 32'd200, 32'd300, 1'b0);
    @(negedge refclk);
    chk("b2b_ready_b", 64'(req0_ready), 64'(1));
    chk("b2b_sum_a",   64'(resp_sum),   64'(30));
    chk("b2b_valid_a", 64'(resp_valid), 64'(1));
    step();
    req0_valid = 1'b0;
    @(negedge refclk);
    chk("b2b_sum_b",   64'(resp_sum),   64'(300));
    chk("b2b_valid_b", 64'(resp_valid), 64'(1));
    step();

    // Table of arithmetic corners
    for (int i = 0; i < 6; i++) begin
      v = tbl[i];
      send(v);
    end
    repeat (2) step();
    @(negedge refclk);
    chk("of_count_table", 64'(of_count), 64'(3));
    step();

    // Contention: grants must alternate starting with port 0
    c0 = 0; c1 = 0;
    set_req(0, 32'd1, 32'd2, 32'd3, 1'b0);
    set_req(1, 32'd3, 32'd4, 32'd7, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge refclk);
      chk("rr_onehot", 64'(req0_ready + req1_ready), 64'(1));
      chk("rr_grant",  64'(req1_ready), 64'(i % 2));
      if (req0_ready) c0++;
      if (req1_ready) c1++;
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_count0", 64'(c0), 64'(3));
    chk("rr_count1", 64'(c1), 64'(3));
    repeat (2) step();

    // Backpressure: held result stays put, no new accept
    resp_ready = 1'b0;
    v = '{0, 32'd5, 32'd6, 32'd11, 1'b0};
    send(v);
    set_req(0, 32'd7, 32'd8, 32'd15, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge refclk);
      chk("bp_ready", 64'(req0_ready), 64'(0));
      chk("bp_valid", 64'(resp_valid), 64'(1));
      chk("bp_sum",   64'(resp_sum),   64'(11));
      step();
    end
    resp_ready = 1'b1;
    @(negedge refclk);
    chk("bp_release_ready", 64'(req0_ready), 64'(1));
    step();
    req0_valid = 1'b0;
    @(negedge refclk);
    chk("bp_next_valid", 64'(resp_valid), 64'(1));
    chk("bp_next_sum",   64'(resp_sum),   64'(15));
    step();

    // Lock loss with a result pending
    resp_ready = 1'b0;
    v = '{0, 32'd9, 32'd9, 32'd18, 1'b0};
    send(v);
    locked = 1'b0;
    set_req(1, 32'd0, 32'd0, 32'd0, 1'b0);
    @(negedge refclk);
    chk("ll_no_accept", 64'(req1_ready), 64'(0));
    step();
    @(negedge refclk);
    chk("ll_valid", 64'(resp_valid), 64'(0));
    chk("ll_run",   64'(run),        64'(0));
    step();
    locked = 1'b1;
    resp_ready = 1'b1;
    wait_run(8);
    step();
    req1_valid = 1'b0;
    repeat (2) step();

    // Reset mid-stream after one conflict moved the round-robin pointer
    resp_ready = 1'b0;
    set_req(0, 32'd1, 32'd2, 32'd3, 1'b0);
    set_req(1, 32'd3, 32'd4, 32'd7, 1'b0);
    @(negedge refclk);
    chk("pre_rst_grant0", 64'(req0_ready), 64'(1));
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    step();
    @(negedge refclk);
    chk("mid_rst_valid", 64'(resp_valid), 64'(0));
    chk("mid_rst_sum",   64'(resp_sum),   64'(0));
    chk("mid_rst_run",   64'(run),        64'(0));
    chk("mid_rst_ofc",   64'(of_count),   64'(0));
    step();
    rst = 1'b0;
    resp_ready = 1'b1;
    wait_run(8);
    step();
    set_req(0, 32'd1, 32'd2, 32'd3, 1'b0);
    set_req(1, 32'd3, 32'd4, 32'd7, 1'b0);
    @(negedge refclk);
    chk("post_rst_ptr0", 64'({req1_ready, req0_ready}), 64'(2'b01));
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) step();
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
- Shares one 32-bit signed adder between two requesters (port 0, port 1), using a valid/ready handshake and round-robin arbitration.
- Holds off all traffic until the PLL `locked` input has been stable, and flushes if lock is lost.
- Sits between client logic and the adder datapath, in the PLL-clocked domain. One result per cycle at full throughput.

Parameters:
- WIDTH, 32, operand/result width.
- LOCK_STABLE, 8, consecutive cycles `locked` must be high before accepting requests (≥1).
- CNT_W, 16, width of the overflow event counter.

Ports:
- refclk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- locked  in  1  PLL lock indicator (already synchronised to refclk).
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_a  in  WIDTH  port 0 operand A.
- req0_b  in  WIDTH  port 0 operand B.
- req1_valid  in  1  port 1 request valid.
- req1_ready  out  1  port 1 request accepted this cycle.
- req1_a  in  WIDTH  port 1 operand A.
- req1_b  in  WIDTH  port 1 operand B.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  1  requester index of the result.
- resp_sum  out  WIDTH  sum.
- resp_of  out  1  signed overflow flag.
- run  out  1  high in RUN state.
- of_count  out  CNT_W  saturating count of delivered overflowed results.

Behaviour:
- Reset: state = WAIT_LOCK, stable counter = 0, rr pointer = 0 (port 0 favoured first). All outputs are 0.
- WAIT_LOCK state:
  - reqN_ready = 0.
  - Stable counter increments while `locked` = 1 and clears when `locked` = 0.
  - Go to RUN when the counter reaches LOCK_STABLE−1 with `locked` = 1, i.e. the LOCK_STABLE-th consecutive high cycle.
- RUN state:
  - run = 1.
  - If `locked` = 0: go to WAIT_LOCK next cycle, clear resp_valid (pending result discarded, not delivered), clear the counter. No request is accepted in that cycle.
- Output slot: single register. slot_free = !resp_valid || resp_ready.
- Grant (combinational, RUN && locked && slot_free):
  - Only one valid request: grant it.
  - Both valid: grant port rr_ptr. rr_ptr then toggles to the other port; it updates only on a two-way conflict.
  - reqN_ready = grant for that port. Handshake completes when valid && ready.
- Compute:
  - On accept, the result registers next cycle: resp_sum = a+b mod 2^WIDTH, resp_id = granted port, resp_valid = 1. Latency is 1 cycle, throughput is 1/cycle.
  - resp_of = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
- Response hold:
  - While resp_valid && !resp_ready, resp_* stay stable and no request is accepted.
  - If resp_ready = 1 in the same cycle as a new accept, the slot is overwritten with the new result (no bubble).
  - If resp_ready = 1 with no accept, resp_valid → 0.
- of_count increments when resp_valid && resp_ready && resp_of, and saturates at all-ones.
- Requesters must hold valid and operands stable until ready. The block does not check this.
- Reset mid-operation: takes effect on the next edge regardless of state; any pending result is lost.

Optional Feature:
- ADDER_SAT_EN defined:
  - On overflow, resp_sum saturates to 0x7FFF_FFFF (positive operands) or 0x8000_0000 (negative operands).
  - resp_of is still asserted.
- ADDER_SAT_EN undefined: wrap-around sum, as above.

Decomposition:
- Package adder_share_pkg holds:
  - WIDTH_DEF = 32.
  - State typedef {WAIT_LOCK, RUN}.
  - Saturation constants SAT_POS and SAT_NEG.
  - Function for signed overflow detection.
- One sub-module: rr_arb2. It is a 2-way round-robin arbiter with inputs req[1:0] and enable, outputs gnt[1:0], and internal pointer update on conflict.

Test Plan:
- Lock gating: rst 5 cycles; toggle locked low after 3 high cycles, then hold high. → run rises exactly 8 cycles after the final rise; no reqN_ready before that.
- Single port: req0 a=10,b=20 then a=100,b=200 back-to-back, resp_ready=1. → resp_sum=30 then 300 on consecutive cycles, resp_id=0, resp_of=0.
- Overflow: req1 a=0x7FFFFFFF, b=1. → resp_sum=0x80000000, resp_of=1, of_count=1. With ADDER_SAT_EN: resp_sum=0x7FFFFFFF. Also a=0x80000000, b=0xFFFFFFFF → of=1, wrap sum=0x7FFFFFFF (SAT: 0x80000000).
- Contention: both valid continuously for 6 cycles. → grants alternate 0,1,0,1,0,1; each port completes 3 transfers.
- Backpressure: resp_ready=0 for 4 cycles with a result pending and req0 valid. → resp_* stable; req0_ready=0. When resp_ready rises, the next result appears on the following cycle with no loss or duplication.
- Lock loss/reset: drop locked with resp_valid=1. → resp_valid=0 next cycle, state WAIT_LOCK. Assert rst mid-stream → all outputs 0 next edge, rr_ptr=0.
